uart_tx_fifo: RTL and testbench

Transmit-side byte buffer that sits directly upstream of `uart_tx`. It accepts bytes from the board logic at arbitrary rate, stores up to DEPTH of them, and launches each one into `uart_tx` through the `start`/`data`/`busy` handshake. Back-to-back bytes then leave on `txd` without the producer polling `tx_busy`.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_byte_fifo.sv | 75 +++++++
 rtl/uart_tx_fifo.sv | 128 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART byte buffers (transmit and receive side).
// Holds the data width and the launch FSM state type reused by both buffers.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    // Launch handshake states: wait for data, hold start, wait for frame end.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        DRAIN  = 2'd2
    } uart_txq_state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO: DEPTH x 8 storage, wrapping read/write pointers and a
// registered occupancy count from which full/empty/level are decoded.
// A push while full or a pop while empty is ignored.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [UART_DATA_W-1:0] push_data_i,
    input  logic                   pop_i,
    output logic [UART_DATA_W-1:0] pop_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [AW:0]            level_o
);

    logic [UART_DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]          wr_ptr_q;
    logic [AW-1:0]          rd_ptr_q;
    logic [AW:0]            count_q;
    logic [AW:0]            count_d;
    logic                   push_ok;
    logic                   pop_ok;

    // Flags come from the registered count, so a push while full is refused
    // even if a pop happens in the same cycle.
    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign level_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Storage array write.
    // NOTE: the array has no reset; stale entries are unreachable while the
    // count says they are empty, and leaving it out keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Occupancy update: a simultaneous push and pop leaves the count unchanged.
    // NOTE: the default assignment first means no path leaves count_d
    // unassigned, so no latch is inferred.
    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; pointers wrap naturally modulo DEPTH.
    // NOTE: state registers use non-blocking assignments so every flop in the
    // design samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit byte buffer in front of uart_tx. Bytes written by the producer are
// queued and launched one at a time through the start/data/busy handshake:
// start is held high (data stable) until busy is seen, then the FSM waits for
// busy to drop before the next launch.
// Optional build macro UART_TX_FIFO_OVF_EN adds a sticky overflow flag (ovf)
// with a clear input (ovf_clr); the data path is the same in both builds.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [UART_DATA_W-1:0] wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [AW:0]            level,
    output logic                   tx_start,
    output logic [UART_DATA_W-1:0] tx_data,
    input  logic                   tx_busy
`ifdef UART_TX_FIFO_OVF_EN
    ,
    output logic                   ovf,
    input  logic                   ovf_clr
`endif
);

    uart_txq_state_t        state_q;
    uart_txq_state_t        state_d;
    logic                   tx_start_q;
    logic                   tx_start_d;
    logic [UART_DATA_W-1:0] tx_data_q;
    logic [UART_DATA_W-1:0] tx_data_d;
    logic                   pop;
    logic [UART_DATA_W-1:0] pop_data;

    uart_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (wr_en),
        .push_data_i (wr_data),
        .pop_i       (pop),
        .pop_data_o  (pop_data),
        .full_o      (full),
        .empty_o     (empty),
        .level_o     (level)
    );

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;

    // Launch FSM next state: pop into the data register, hold start until
    // busy is sampled, then wait out the frame.
    always_comb begin
        state_d    = state_q;
        tx_start_d = tx_start_q;
        tx_data_d  = tx_data_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                // A foreign transfer holding busy defers the pop.
                if (!empty && !tx_busy) begin
                    pop        = 1'b1;
                    tx_data_d  = pop_data;
                    tx_start_d = 1'b1;
                    state_d    = LAUNCH;
                end
            end
            LAUNCH: begin
                // Level-held start tolerates a uart_tx that only samples on its baud tick.
                if (tx_busy) begin
                    tx_start_d = 1'b0;
                    state_d    = DRAIN;
                end
            end
            DRAIN: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                tx_start_d = 1'b0;
            end
        endcase
    end

    // FSM state and registered handshake outputs; tx_data keeps the last byte sent.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

`ifdef UART_TX_FIFO_OVF_EN
    logic ovf_q;
    logic ovf_d;

    assign ovf = ovf_q;

    // Sticky overflow: a refused write sets it, ovf_clr clears it, set wins.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr)       ovf_d = 1'b0;
        if (wr_en && full) ovf_d = 1'b1;
    end

    // Overflow flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo. A behavioural uart_tx model accepts each launched
// byte after a programmable delay and stays busy for a programmable frame
// length; every byte it accepts is compared against a queue of the bytes the
// FIFO is expected to deliver, in write order.
module tb_uart_tx_fifo;

    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic          empty;
    logic [AW:0]   level;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_busy;
`ifdef UART_TX_FIFO_OVF_EN
    logic          ovf;
    logic          ovf_clr;
`endif

    // Busy from the uart_tx model, plus a stimulus-driven foreign transfer.
    logic          m_busy;
    logic          hold_busy;
    assign tx_busy = m_busy | hold_busy;

    int            checks = 0;
    int            errors = 0;
    logic [7:0]    exp_q[$];
    int            captured = 0;
    int            busy_delay = 0;
    int            frame_len = 3;

    bit            m_waiting = 1'b0;
    int            m_wait = 0;
    int            m_frame = 0;
    logic [7:0]    m_first = 8'h00;

    uart_tx_fifo #(
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy)
`ifdef UART_TX_FIFO_OVF_EN
        ,
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // uart_tx model and scoreboard monitor, evaluated on the falling edge.
    always @(negedge clk) begin
        logic [7:0] exp_b;
        if (rst) begin
            m_busy    = 1'b0;
            m_waiting = 1'b0;
            m_frame   = 0;
        end else if (m_busy) begin
            check("start_low_while_busy", {31'd0, tx_start}, 32'd0);
            if (m_frame <= 1) m_busy = 1'b0;
            else m_frame--;
        end else if (tx_start) begin
            if (!m_waiting) begin
                m_waiting = 1'b1;
                m_wait    = 0;
                m_first   = tx_data;
            end else begin
                check("tx_data_stable", {24'd0, tx_data}, {24'd0, m_first});
            end
            if (m_wait >= busy_delay) begin
                m_busy    = 1'b1;
                m_waiting = 1'b0;
                m_frame   = frame_len;
                captured++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got 0x%0h with nothing expected at %0t", m_first, $time);
                end else begin
                    exp_b = exp_q.pop_front();
                    check("byte_order", {24'd0, m_first}, {24'd0, exp_b});
                end
            end else begin
                m_wait++;
            end
        end
    end

    task automatic write_byte(input logic [7:0] d, input bit expect_accept);
        wr_en   = 1'b1;
        wr_data = d;
        if (expect_accept) exp_q.push_back(d);
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Wait until every expected byte has been sent and everything is idle.
    task automatic wait_quiet(input string name, input int budget);
        int n = 0;
        while (!(exp_q.size() == 0 && !m_busy && !m_waiting && !tx_start && empty) && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s: timeout after %0d cycles, %0d bytes outstanding", name, n, exp_q.size());
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int cap0;
        int n;
        rst       = 1'b1;
        wr_en     = 1'b0;
        wr_data   = 8'h00;
        hold_busy = 1'b0;
        m_busy    = 1'b0;
`ifdef UART_TX_FIFO_OVF_EN
        ovf_clr   = 1'b0;
`endif
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_empty",    {31'd0, empty},    32'd1);
        check("rst_full",     {31'd0, full},     32'd0);
        check("rst_level",    {28'd0, level},    32'd0);
        check("rst_tx_start", {31'd0, tx_start}, 32'd0);
        check("rst_tx_data",  {24'd0, tx_data},  32'd0);
`ifdef UART_TX_FIFO_OVF_EN
        check("rst_ovf",      {31'd0, ovf},      32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Single byte: one-cycle latency from write to start.
        busy_delay = 2;
        frame_len  = 4;
        write_byte(8'hA5, 1'b1);
        check("single_level1",     {28'd0, level},    32'd1);
        check("single_start_pre",  {31'd0, tx_start}, 32'd0);
        @(negedge clk);
        check("single_start",      {31'd0, tx_start}, 32'd1);
        check("single_data",       {24'd0, tx_data},  32'hA5);
        check("single_empty",      {31'd0, empty},    32'd1);
        wait_quiet("single_drain", 100);
        check("single_data_held",  {24'd0, tx_data},  32'hA5);

        // Burst ordering.
        busy_delay = 1;
        frame_len  = 5;
        cap0 = captured;
        for (int i = 1; i <= 5; i++) write_byte(8'(i), 1'b1);
        wait_quiet("burst_drain", 300);
        check("burst_count", captured - cap0, 32'd5);

        // Delayed busy: start held 20 cycles, exactly one frame.
        busy_delay = 20;
        frame_len  = 3;
        cap0 = captured;
        write_byte(8'h3C, 1'b1);
        wait_quiet("delayed_drain", 200);
        check("delayed_frames", captured - cap0, 32'd1);

        // Full / overflow with a foreign transfer blocking the launch.
        busy_delay = 0;
        frame_len  = 3;
        hold_busy  = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) write_byte(8'($urandom), i < DEPTH);
        check("ovf_full",     {31'd0, full},     32'd1);
        check("ovf_level",    {28'd0, level},    32'(DEPTH));
        check("ovf_empty",    {31'd0, empty},    32'd0);
        check("ovf_no_start", {31'd0, tx_start}, 32'd0);
`ifdef UART_TX_FIFO_OVF_EN
        check("ovf_set",      {31'd0, ovf},      32'd1);
        @(negedge clk);
        check("ovf_sticky",   {31'd0, ovf},      32'd1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("ovf_cleared",  {31'd0, ovf},      32'd0);
`endif
        hold_busy = 1'b0;
        wait_quiet("ovf_drain", 2000);

        // Simultaneous push and pop at level 3.
        hold_busy = 1'b1;
        for (int i = 0; i < 3; i++) write_byte(8'($urandom), 1'b1);
        check("simul_level_pre", {28'd0, level}, 32'd3);
        hold_busy = 1'b0;
        write_byte(8'($urandom), 1'b1);
        check("simul_level",     {28'd0, level},    32'd3);
        check("simul_start",     {31'd0, tx_start}, 32'd1);
        wait_quiet("simul_drain", 1000);

        // Randomized traffic; pointers wrap many times.
        for (int c = 0; c < 400; c++) begin
            busy_delay = $urandom_range(0, 3);
            frame_len  = $urandom_range(1, 6);
            if ($urandom_range(0, 1) == 1 && exp_q.size() < DEPTH) begin
                wr_en   = 1'b1;
                wr_data = 8'($urandom);
                exp_q.push_back(wr_data);
            end else begin
                wr_en = 1'b0;
            end
            @(negedge clk);
        end
        wr_en = 1'b0;
        wait_quiet("random_drain", 3000);

        // Reset mid-operation while in LAUNCH with four bytes queued.
        busy_delay = 50;
        frame_len  = 3;
        for (int i = 0; i < 5; i++) write_byte(8'($urandom), 1'b1);
        n = 0;
        while (!(tx_start && level == 4) && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 10) begin
            errors++;
            $display("FAIL launch_level4: timeout waiting for launch with level 4");
        end
        cap0 = captured;
        @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_tx_start", {31'd0, tx_start}, 32'd0);
        check("mid_rst_tx_data",  {24'd0, tx_data},  32'd0);
        check("mid_rst_empty",    {31'd0, empty},    32'd1);
        check("mid_rst_level",    {28'd0, level},    32'd0);
`ifdef UART_TX_FIFO_OVF_EN
        check("mid_rst_ovf",      {31'd0, ovf},      32'd0);
`endif
        repeat (30) @(negedge clk);
        check("mid_rst_no_frames", captured - cap0, 32'd0);
        check("mid_rst_still_empty", {31'd0, empty}, 32'd1);

        check("final_outstanding", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
